// File: rtl/midi_pkg.sv
// -----------------------------------------------------------------------------
// midi_pkg
// Shared definitions for the MIDI output path:
//   - midi_state_t       : serializer state encoding (IDLE/START/DATA/STOP)
//   - STATUS_* constants : MIDI status byte range boundaries
//   - FRAME_BITS         : 8N1 frame length in bit cells
//   - helper functions   : status classification and message byte selection
// -----------------------------------------------------------------------------
package midi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } midi_state_t;

    localparam logic [7:0] STATUS_CHANNEL  = 8'h80;  // first channel voice status
    localparam logic [7:0] STATUS_SYSCOM   = 8'hF0;  // first system common status
    localparam logic [7:0] STATUS_REALTIME = 8'hF8;  // first real-time status

    localparam int FRAME_BITS = 10;  // start + 8 data + stop

    function automatic logic is_channel_status(input logic [7:0] b);
        return (b >= STATUS_CHANNEL) && (b < STATUS_SYSCOM);
    endfunction

    function automatic logic is_syscom_status(input logic [7:0] b);
        return (b >= STATUS_SYSCOM) && (b < STATUS_REALTIME);
    endfunction

    // Byte idx of a message laid out as status, data1, data2.
    function automatic logic [7:0] pick_byte(input logic [1:0] idx,
                                             input logic [7:0] s,
                                             input logic [7:0] d1,
                                             input logic [7:0] d2);
        case (idx)
            2'd0:    return s;
            2'd1:    return d1;
            default: return d2;
        endcase
    endfunction

endpackage

// File: rtl/midi_uart_tx.sv
// -----------------------------------------------------------------------------
// midi_uart_tx
// 8N1 byte serializer. Each bit cell lasts DIV clocks. A byte is taken on
// tx_valid && tx_ready; tx_ready is high while idle and also in the final
// clock of a stop bit, so a waiting byte follows with no idle gap.
// Ports:
//   CLK, RST   : clock, synchronous active-high reset
//   tx_valid   : a byte is offered
//   tx_ready   : the serializer takes the offered byte this clock
//   tx_data    : byte to send, LSB first
//   line       : registered serial line, 1 when idle
//   state      : current serializer state
// -----------------------------------------------------------------------------
module midi_uart_tx
    import midi_pkg::*;
#(
    parameter int DIV = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic [7:0]  tx_data,
    output logic        line,
    output midi_state_t state
);

    localparam int             CW       = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  DIV_LAST = CW'(DIV - 1);
    localparam logic [2:0]     LAST_BIT = 3'(FRAME_BITS - 3);

    midi_state_t   state_q, state_d;
    logic [CW-1:0] div_q, div_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          line_q, line_d;
    logic          tick;

    assign tick = (div_q == DIV_LAST);

    // State register.
    // NOTE: sequential state is written with <= so every flop samples the
    // values from before the edge; = here would create order-dependent races.
    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: the shift register is reset together with the control
            // state only to keep the block free of X; its contents are never
            // observed before a new byte is loaded.
            state_q <= ST_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            line_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            line_q  <= line_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves one
        // unassigned and no latch is inferred.
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        sh_d    = sh_q;

        case (state_q)
            ST_IDLE: begin
                if (tx_valid) begin
                    state_d = ST_START;
                    sh_d    = tx_data;
                    div_d   = '0;
                    bit_d   = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                    div_d   = '0;
                end else begin
                    div_d = div_q + CW'(1);
                end
            end
            ST_DATA: begin
                if (tick) begin
                    div_d = '0;
                    sh_d  = {1'b0, sh_q[7:1]};
                    if (bit_q == LAST_BIT) begin
                        state_d = ST_STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    div_d = div_q + CW'(1);
                end
            end
            ST_STOP: begin
                if (tick) begin
                    div_d = '0;
                    if (tx_valid) begin
                        state_d = ST_START;
                        sh_d    = tx_data;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    div_d = div_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The line is computed from the next state and registered so the pin
        // never glitches on state decode.
        line_d = 1'b1;
        if (state_d == ST_START) begin
            line_d = 1'b0;
        end else if (state_d == ST_DATA) begin
            line_d = sh_d[0];
        end
    end

    // Outputs.
    always_comb begin
        tx_ready = (state_q == ST_IDLE) || ((state_q == ST_STOP) && tick);
    end

    assign line  = line_q;
    assign state = state_q;

endmodule

// File: rtl/midiout_msg.sv
// -----------------------------------------------------------------------------
// midiout_msg
// Sends a complete MIDI message (status, data1, data2, truncated to len bytes)
// out of a serial MIDI port, with optional running-status compression and
// optional output inversion for an open-collector optoisolator card.
// Ports:
//   CLK, RST      : clock, synchronous active-high reset
//   msg_valid     : a message is offered
//   msg_ready     : the block can accept a message (serializer idle)
//   status        : MIDI status byte
//   data1, data2  : data bytes
//   len           : bytes in the message including status, 0..3
//   busy          : a frame is being shifted
//   MIDIOUT       : serial line, inverted when INVERT_OUT=1
// -----------------------------------------------------------------------------
module midiout_msg
    import midi_pkg::*;
#(
    parameter int CLK_HZ         = 50000000,
    parameter int BAUD           = 31250,
    parameter int RUNNING_STATUS = 1,
    parameter int INVERT_OUT     = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       msg_valid,
    output logic       msg_ready,
    input  logic [7:0] status,
    input  logic [7:0] data1,
    input  logic [7:0] data2,
    input  logic [1:0] len,
    output logic       busy,
    output logic       MIDIOUT
);

    localparam int DIV = CLK_HZ / BAUD;

    if (DIV < 2) begin : g_div_check
        $error("midiout_msg: CLK_HZ/BAUD must be at least 2");
    end

    midi_state_t tx_state;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        line;

    logic [7:0]  status_q, data1_q, data2_q;
    logic [1:0]  len_q;
    logic [1:0]  byte_idx_q;    // index of the byte currently on the wire
    logic [7:0]  last_status_q;
    logic        rs_valid_q;

    logic        accept;
    logic        rs_hit;
    logic [1:0]  first_idx;
    logic        send_first;
    logic [1:0]  next_idx;

    assign msg_ready = (tx_state == ST_IDLE);
    assign busy      = (tx_state != ST_IDLE);
    assign accept    = msg_valid && msg_ready;

    // A repeated channel status is dropped; the message then starts at data1.
    assign rs_hit     = (RUNNING_STATUS != 0) && rs_valid_q &&
                        is_channel_status(status) && (status == last_status_q);
    assign first_idx  = rs_hit ? 2'd1 : 2'd0;
    assign send_first = (first_idx < len);
    assign next_idx   = byte_idx_q + 2'd1;

    // The first byte is handed to the serializer straight from the inputs in
    // the accept cycle, so its start bit appears on the next clock. Later
    // bytes come from the latched copy and are taken at the end of each stop.
    always_comb begin
        tx_valid = 1'b0;
        tx_data  = '0;
        if (msg_ready) begin
            tx_valid = msg_valid && send_first;
            tx_data  = pick_byte(first_idx, status, data1, data2);
        end else begin
            tx_valid = (next_idx < len_q);
            tx_data  = pick_byte(next_idx, status_q, data1_q, data2_q);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            status_q      <= '0;
            data1_q       <= '0;
            data2_q       <= '0;
            len_q         <= '0;
            byte_idx_q    <= '0;
            last_status_q <= '0;
            rs_valid_q    <= 1'b0;
        end else begin
            if (accept) begin
                status_q   <= status;
                data1_q    <= data1;
                data2_q    <= data2;
                len_q      <= len;
                byte_idx_q <= first_idx;
            end else if (tx_valid && tx_ready) begin
                byte_idx_q <= next_idx;
            end

            // Running-status bookkeeping; len=0 sends nothing and changes
            // nothing, real-time and data-range bytes leave it alone.
            if ((RUNNING_STATUS != 0) && accept && (len != 2'd0)) begin
                if (is_channel_status(status)) begin
                    last_status_q <= status;
                    rs_valid_q    <= 1'b1;
                end else if (is_syscom_status(status)) begin
                    rs_valid_q    <= 1'b0;
                end
            end
        end
    end

    midi_uart_tx #(
        .DIV(DIV)
    ) u_tx (
        .CLK      (CLK),
        .RST      (RST),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .line     (line),
        .state    (tx_state)
    );

    assign MIDIOUT = (INVERT_OUT != 0) ? ~line : line;

endmodule

// File: tb/tb_midiout_msg.sv
`timescale 1ns/1ps
// Scoreboard bench: two instances share the message inputs.
//   dut_a : RUNNING_STATUS=1, INVERT_OUT=1
//   dut_b : RUNNING_STATUS=0, INVERT_OUT=0
// Expected bytes are queued when a message is issued; one monitor per
// instance decodes frames from the serial line and pops the queue.
module tb_midiout_msg;

    localparam int CLK_HZ = 500000;
    localparam int BAUD   = 31250;
    localparam int DIV    = 16;
    localparam int FRAME  = 10 * DIV;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       valid_a = 1'b0;
    logic       valid_b = 1'b0;
    logic [7:0] status = '0;
    logic [7:0] data1 = '0;
    logic [7:0] data2 = '0;
    logic [1:0] len = '0;
    logic       ready_a, busy_a, midiout_a;
    logic       ready_b, busy_b, midiout_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         skip;
        logic [7:0] data;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    midiout_msg #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .RUNNING_STATUS(1), .INVERT_OUT(1)) dut_a (
        .CLK(CLK), .RST(RST), .msg_valid(valid_a), .msg_ready(ready_a),
        .status(status), .data1(data1), .data2(data2), .len(len),
        .busy(busy_a), .MIDIOUT(midiout_a)
    );

    midiout_msg #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .RUNNING_STATUS(0), .INVERT_OUT(0)) dut_b (
        .CLK(CLK), .RST(RST), .msg_valid(valid_b), .msg_ready(ready_b),
        .status(status), .data1(data1), .data2(data2), .len(len),
        .busy(busy_b), .MIDIOUT(midiout_b)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int which, input logic [7:0] b, input bit skip);
        exp_t e;
        e.skip = skip;
        e.data = b;
        if (which == 0) q_a.push_back(e);
        else            q_b.push_back(e);
    endtask

    // Un-inverted serial line of each instance.
    function automatic logic mon_line(input int which);
        return (which == 0) ? ~midiout_a : midiout_b;
    endfunction

    task automatic monitor(input int which);
        logic [7:0] b;
        logic       start_bit, stop_bit;
        exp_t       e;
        bit         have;
        forever begin
            @(negedge CLK);
            if (mon_line(which) === 1'b0) begin
                // Detected half a clock into the start cell; move to its centre.
                repeat (DIV / 2 - 1) @(negedge CLK);
                start_bit = mon_line(which);
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge CLK);
                    b[i] = mon_line(which);
                end
                repeat (DIV) @(negedge CLK);
                stop_bit = mon_line(which);
                have = 1'b0;
                if (which == 0) begin
                    if (q_a.size() != 0) begin e = q_a.pop_front(); have = 1'b1; end
                end else begin
                    if (q_b.size() != 0) begin e = q_b.pop_front(); have = 1'b1; end
                end
                check((which == 0) ? "frame_expected_a" : "frame_expected_b", 32'(have), 32'd1);
                if (have && !e.skip) begin
                    check((which == 0) ? "frame_byte_a" : "frame_byte_b", 32'(b), 32'(e.data));
                    check((which == 0) ? "framing_a" : "framing_b", {30'd0, start_bit, stop_bit}, 32'b01);
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    // Issue one message to both instances. a_omit: dut_a is expected to drop
    // the status byte under running status.
    task automatic send_msg(input logic [7:0] s, input logic [7:0] d1, input logic [7:0] d2,
                            input logic [1:0] l, input bit a_omit);
        logic [7:0] bytes [3];
        int na, nb, k, ca, cb;
        bytes[0] = s;
        bytes[1] = d1;
        bytes[2] = d2;
        nb = int'(l);
        na = (l == 2'd0) ? 0 : (nb - (a_omit ? 1 : 0));
        for (int i = (a_omit ? 1 : 0); i < nb; i++) push(0, bytes[i], 1'b0);
        for (int i = 0; i < nb; i++) push(1, bytes[i], 1'b0);

        k = 0;
        @(negedge CLK);
        while (!(ready_a && ready_b) && k < 2000) begin
            @(negedge CLK);
            k++;
        end
        check("ready_before_send", {30'd0, ready_a, ready_b}, 32'b11);
        status = s; data1 = d1; data2 = d2; len = l;
        valid_a = 1'b1; valid_b = 1'b1;
        @(posedge CLK);
        #1;
        valid_a = 1'b0; valid_b = 1'b0;
        status = 8'($urandom); data1 = 8'($urandom); data2 = 8'($urandom); len = 2'($urandom);

        // Start bit one clock after accept; dut_a's pin is inverted.
        check("start_latency_a", 32'(midiout_a), (na > 0) ? 32'd1 : 32'd0);
        check("start_latency_b", 32'(midiout_b), (nb > 0) ? 32'd0 : 32'd1);
        check("busy_a", 32'(busy_a), (na > 0) ? 32'd1 : 32'd0);

        ca = ready_a ? 0 : -1;
        cb = ready_b ? 0 : -1;
        k = 0;
        while ((ca < 0 || cb < 0) && k < 2000) begin
            @(posedge CLK);
            #1;
            k++;
            if (ca < 0 && ready_a) ca = k;
            if (cb < 0 && ready_b) cb = k;
        end
        check("ready_low_cycles_a", 32'(ca), 32'(FRAME * na));
        check("ready_low_cycles_b", 32'(cb), 32'(FRAME * nb));
    endtask

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, acc, k;
        int acc_t [3];

        repeat (3) @(posedge CLK);
        #1;
        check("reset_ready_a", 32'(ready_a), 32'd1);
        check("reset_busy_a", 32'(busy_a), 32'd0);
        check("reset_midiout_a", 32'(midiout_a), 32'd0);
        check("reset_ready_b", 32'(ready_b), 32'd1);
        check("reset_midiout_b", 32'(midiout_b), 32'd1);
        RST = 1'b0;

        send_msg(8'h90, 8'h3C, 8'h7F, 2'd3, 1'b0);  // full note-on
        send_msg(8'h90, 8'h40, 8'h60, 2'd3, 1'b1);  // running status on A
        send_msg(8'hF8, 8'h00, 8'h00, 2'd1, 1'b0);  // real-time keeps status
        send_msg(8'h90, 8'h40, 8'h60, 2'd3, 1'b1);
        send_msg(8'hF6, 8'h00, 8'h00, 2'd1, 1'b0);  // system common clears it
        send_msg(8'h90, 8'h40, 8'h60, 2'd3, 1'b0);  // status resent
        send_msg(8'h80, 8'h01, 8'h02, 2'd0, 1'b0);  // len=0 no-op
        send_msg(8'h90, 8'h11, 8'h22, 2'd1, 1'b1);  // becomes a no-op on A
        send_msg(8'hC0, 8'h05, 8'hAA, 2'd2, 1'b0);  // truncated to 2 bytes
        send_msg(8'hC0, 8'h07, 8'hBB, 2'd2, 1'b1);

        // Back-to-back on dut_a with msg_valid held high.
        for (int i = 0; i < 3; i++) begin
            if (i == 0) push(0, 8'hB0, 1'b0);
            push(0, 8'h07, 1'b0);
            push(0, 8'h64, 1'b0);
        end
        status = 8'hB0; data1 = 8'h07; data2 = 8'h64; len = 2'd3;
        valid_a = 1'b1;
        cyc = 0;
        acc = 0;
        acc_t[0] = 0; acc_t[1] = 0; acc_t[2] = 0;
        while (acc < 3 && cyc < 3000) begin
            @(negedge CLK);
            if (ready_a) begin
                acc_t[acc] = cyc;
                acc++;
            end
            @(posedge CLK);
            cyc++;
        end
        #1;
        valid_a = 1'b0;
        check("b2b_accepts", 32'(acc), 32'd3);
        check("b2b_gap_first", 32'(acc_t[1] - acc_t[0]), 32'(3 * FRAME + 1));
        check("b2b_gap_second", 32'(acc_t[2] - acc_t[1]), 32'(2 * FRAME + 1));
        k = 0;
        while (!ready_a && k < 1000) begin
            @(posedge CLK);
            #1;
            k++;
        end
        check("b2b_idle", 32'(ready_a), 32'd1);

        // Reset during the data bits of the second frame.
        push(0, 8'h90, 1'b0); push(0, 8'h3C, 1'b1);
        push(1, 8'h90, 1'b0); push(1, 8'h3C, 1'b1);
        @(negedge CLK);
        status = 8'h90; data1 = 8'h3C; data2 = 8'h7F; len = 2'd3;
        valid_a = 1'b1; valid_b = 1'b1;
        @(posedge CLK);
        #1;
        valid_a = 1'b0; valid_b = 1'b0;
        repeat (FRAME + 39) @(posedge CLK);
        #1;
        check("pre_reset_busy_a", 32'(busy_a), 32'd1);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        check("mid_reset_midiout_a", 32'(midiout_a), 32'd0);
        check("mid_reset_ready_a", 32'(ready_a), 32'd1);
        check("mid_reset_busy_a", 32'(busy_a), 32'd0);
        check("mid_reset_midiout_b", 32'(midiout_b), 32'd1);
        check("mid_reset_ready_b", 32'(ready_b), 32'd1);
        repeat (200) @(posedge CLK);

        send_msg(8'h90, 8'h40, 8'h60, 2'd3, 1'b0);  // status sent again after reset

        repeat (20) @(posedge CLK);
        check("queue_empty_a", 32'(q_a.size()), 32'd0);
        check("queue_empty_b", 32'(q_b.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/midiout_msg.md
MIDIOUT_MSG -- requirements
Module: midiout_msg

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 31250, MIDI bit rate.
REQ-003 SHALL have parameter RUNNING_STATUS, default 1; 1 enables running-status compression.
REQ-004 SHALL have parameter INVERT_OUT, default 1; 1 inverts the line for the open-collector optoisolator card.
REQ-005 SHALL have port CLK, input, 1 bit, the single clock; all state SHALL change on its rising edge.
REQ-006 SHALL have port RST, input, 1 bit; reset is synchronous and active-high.
REQ-007 SHALL have port msg_valid, input, 1 bit; a message is offered.
REQ-008 SHALL have port msg_ready, output, 1 bit; the block can accept a message.
REQ-009 SHALL have port status, input, 8 bits; the MIDI status byte.
REQ-010 SHALL have port data1, input, 8 bits; the first data byte.
REQ-011 SHALL have port data2, input, 8 bits; the second data byte.
REQ-012 SHALL have port len, input, 2 bits; the byte count of the message, 0..3, including status.
REQ-013 SHALL have port busy, output, 1 bit; high while a frame is being shifted.
REQ-014 SHALL have port MIDIOUT, output, 1 bit; the serial line after optional inversion.

Function
REQ-015 SHALL derive DIV = CLK_HZ/BAUD, using integer division; each bit lasts exactly DIV clocks. DIV < 2 SHALL be a parameter error.
REQ-016 SHALL frame each byte 8N1: start bit 0, data bits LSB first, stop bit 1. Each frame is 10*DIV clocks.
REQ-017 SHALL drive the internal line at 1 when idle. MIDIOUT = ~line when INVERT_OUT=1, otherwise MIDIOUT = line.
REQ-018 SHALL assert msg_ready only in state IDLE. A message is accepted in the cycle where msg_valid && msg_ready.
REQ-019 SHALL latch status, data1, data2 and len on accept. Input changes after accept SHALL have no effect.
REQ-020 SHALL support states IDLE, START, DATA, STOP, with a byte index 0..2 and a bit index 0..7.
REQ-021 SHALL make these transitions:
- IDLE->START on accept, when at least one byte is to be sent.
- START->DATA after DIV clocks.
- DATA->STOP after 8*DIV clocks.
- STOP->START for the next byte, with no idle gap.
- STOP->IDLE after the last byte.
REQ-022 SHALL drive the start bit of the first byte beginning the clock after accept (latency 1). msg_ready SHALL return high the clock after the final stop bit completes.
REQ-023 SHALL treat len=0 as a no-op: the message is accepted, nothing is sent, and the block stays IDLE with msg_ready high.
REQ-024 SHALL send bytes in the order status, data1, data2, truncated to len bytes.
REQ-025 When RUNNING_STATUS=1, SHALL keep last_status plus a valid flag. A channel status (0x80..0xEF) equal to last_status with the flag set SHALL omit the status byte. If len=1, the message then becomes a no-op per REQ-023.
REQ-026 SHALL update running status per message type:
- A sent channel status sets last_status and the flag.
- System common 0xF0..0xF7 clears the flag.
- Real-time 0xF8..0xFF leaves it unchanged.
REQ-027 SHALL keep last_status and the flag constant when RUNNING_STATUS=0; every status byte is then sent.
REQ-028 SHALL assert busy from START of the first byte through the end of the last STOP.

Reset
REQ-029 SHALL apply these values when RST=1 at a clock edge, regardless of state:
- state IDLE
- line 1 (MIDIOUT = 0 when INVERT_OUT=1)
- msg_ready 1
- busy 0
- running-status flag 0
- divider and bit/byte counters 0
REQ-030 SHALL abandon a partially sent frame on mid-operation reset, with the line returning to idle immediately. Reset SHALL take priority over a simultaneous accept.

Structure
REQ-031 SHALL place in shared package midi_pkg:
- state encoding typedef
- status range constants (0x80, 0xF0, 0xF8)
- FRAME_BITS = 10
REQ-032 SHALL instantiate one sub-module, midi_uart_tx, a parametrised byte serializer with a byte valid/ready handshake and DIV divider. midiout_msg holds the message sequencing and running-status logic.

Verification (CLK_HZ=500000, BAUD=31250, so DIV=16)
REQ-033 Accept 0x90,0x3C,0x7F with len=3 -> 30 bit cells of 16 clocks each: 0,0x90 LSB-first,1 / 0,0x3C,1 / 0,0x7F,1. msg_ready is low for 480 clocks.
REQ-034 Send 0x90,0x40,0x60 with len=3 right after REQ-033, RUNNING_STATUS=1 -> only 2 frames (0x40,0x60), 320 clocks. With RUNNING_STATUS=0 -> 3 frames.
REQ-035 Send 0x90 note, then 0xF8 with len=1, then a 0x90 note -> frames 0xF8, then 0x40,0x60; running status is preserved. Replacing 0xF8 with 0xF6 -> 0x90 is resent.
REQ-036 Send len=0 -> no line activity, and msg_ready stays high. Hold msg_valid high continuously -> messages go back to back, with exactly a 1-clock IDLE between the last stop and the next start.
REQ-037 Assert RST for 1 clock in the DATA state of byte 2 -> line idle next clock, and msg_ready=1. The next 0x90 message is sent with its status byte.
REQ-038 INVERT_OUT=1 -> MIDIOUT is the bitwise complement of the line in every scenario. The reset value is MIDIOUT=0.
